// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: OFF / ON / BLINK / BREATHE per channel,
// sharing one tick prescaler and one free-running PWM counter.
module led_pattern_gen #(
  parameter int CHANNELS     = 4,
  parameter int CLK_DIV      = 46875,
  parameter int PWM_W        = 8,
  parameter int RESET_MODE   = 2,
  parameter int RESET_PERIOD = 127
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_wr_ch,
  input  logic [1:0]                                      i_wr_mode,
  input  logic [7:0]                                      i_wr_period,
  output logic [CHANNELS-1:0]                             o_led,
  output logic                                            o_tick
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_W-1:0]    r_pwm_cnt;
  logic                w_tick;
  logic [CHANNELS-1:0] w_led;

  assign w_tick = (r_pre_cnt == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
      o_tick    <= 1'b0;
      o_led     <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      o_tick    <= w_tick;
      o_led     <= w_led;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    mode_t            r_mode,   w_mode_next;
    logic [7:0]       r_period, w_period_next;
    logic [7:0]       r_phase,  w_phase_next;
    logic             r_blink,  w_blink_next;
    logic             r_dir,    w_dir_next;
    logic [PWM_W-1:0] r_duty,   w_duty_next;
    logic             w_hit;
    logic             w_step;

    // Out-of-range channel numbers never equal a generated index, so they drop out here.
    assign w_hit  = i_wr_en && (i_wr_ch == CH_W'(gi));
    assign w_step = w_tick && (r_phase == r_period);

    always_comb begin
      w_mode_next   = r_mode;
      w_period_next = r_period;
      w_phase_next  = r_phase;
      w_blink_next  = r_blink;
      w_dir_next    = r_dir;
      w_duty_next   = r_duty;
      if (w_hit) begin
        w_mode_next   = mode_t'(i_wr_mode);
        w_period_next = i_wr_period;
        w_phase_next  = 8'd0;
        w_blink_next  = 1'b0;
        w_dir_next    = 1'b0;
        w_duty_next   = '0;
      end else if (w_tick) begin
        w_phase_next = w_step ? 8'd0 : r_phase + 8'd1;
        if (w_step) begin
          case (r_mode)
            MODE_BLINK: w_blink_next = ~r_blink;
            MODE_BREATHE: begin
              // Direction flips in the same step that reaches an end, so duty never wraps.
              if (!r_dir) begin
                if (r_duty != DUTY_MAX) w_duty_next = r_duty + 1'b1;
                if (r_duty == DUTY_MAX - 1'b1) w_dir_next = 1'b1;
              end else begin
                if (r_duty != '0) w_duty_next = r_duty - 1'b1;
                if (r_duty == PWM_W'(1)) w_dir_next = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_mode   <= mode_t'(2'(RESET_MODE));
        r_period <= 8'(RESET_PERIOD);
        r_phase  <= 8'd0;
        r_blink  <= 1'b0;
        r_dir    <= 1'b0;
        r_duty   <= '0;
      end else begin
        r_mode   <= w_mode_next;
        r_period <= w_period_next;
        r_phase  <= w_phase_next;
        r_blink  <= w_blink_next;
        r_dir    <= w_dir_next;
        r_duty   <= w_duty_next;
      end
    end

    assign w_led[gi] = (r_mode == MODE_ON)      ? 1'b1 :
                       (r_mode == MODE_BLINK)   ? r_blink :
                       (r_mode == MODE_BREATHE) ? (r_duty > r_pwm_cnt) :
                                                  1'b0;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a 4-channel instance and a 5-channel instance
// (3-bit channel port) compared cycle by cycle against a tick-count model.
module tb_led_pattern_gen;

  localparam int D  = 4;
  localparam int PW = 4;
  localparam int DMAX = (1 << PW) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [1:0] wr_ch_a = '0;
  logic [2:0] wr_ch_b = '0;
  logic [1:0] wr_mode_a = '0, wr_mode_b = '0;
  logic [7:0] wr_per_a = '0, wr_per_b = '0;
  logic [3:0] o_led_a;
  logic [4:0] o_led_b;
  logic       o_tick_a, o_tick_b;

  int checks = 0;
  int failures = 0;

  led_pattern_gen #(.CHANNELS(4), .CLK_DIV(D), .PWM_W(PW), .RESET_MODE(2), .RESET_PERIOD(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en_a), .i_wr_ch(wr_ch_a),
    .i_wr_mode(wr_mode_a), .i_wr_period(wr_per_a), .o_led(o_led_a), .o_tick(o_tick_a));

  led_pattern_gen #(.CHANNELS(5), .CLK_DIV(D), .PWM_W(PW), .RESET_MODE(2), .RESET_PERIOD(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en_b), .i_wr_ch(wr_ch_b),
    .i_wr_mode(wr_mode_b), .i_wr_period(wr_per_b), .o_led(o_led_b), .o_tick(o_tick_b));

  always #5 clk = ~clk;

  // Model: each channel is described by its mode, period and the number of
  // ticks seen since its last write; blink/duty are derived arithmetically.
  int          nch [2] = '{4, 5};
  int          k_m [2];
  int          m_mode [2][16];
  int          m_per  [2][16];
  int          m_n    [2][16];
  logic [15:0] exp_led [2];
  logic        exp_tick [2];

  function automatic int tri_duty(int s);
    int r = s % (2 * DMAX);
    return (r <= DMAX) ? r : 2 * DMAX - r;
  endfunction

  function automatic logic model_out(int d, int c, int pwm);
    int steps = m_n[d][c] / (m_per[d][c] + 1);
    case (m_mode[d][c])
      1: return 1'b1;
      2: return 1'((steps % 2) == 1);
      3: return 1'(tri_duty(steps) > pwm);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      k_m[d] = 0;
      exp_led[d] = '0;
      exp_tick[d] = 1'b0;
      for (int c = 0; c < 16; c++) begin
        m_mode[d][c] = 2;
        m_per[d][c]  = 1;
        m_n[d][c]    = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        int          k   = k_m[d] + 1;
        bit          tk  = ((k % D) == 0);
        int          pwm = k_m[d] % (1 << PW);
        logic [15:0] nl  = '0;
        bit          we  = (d == 0) ? wr_en_a : wr_en_b;
        int          wc  = (d == 0) ? int'(wr_ch_a) : int'(wr_ch_b);
        int          wm  = (d == 0) ? int'(wr_mode_a) : int'(wr_mode_b);
        int          wp  = (d == 0) ? int'(wr_per_a) : int'(wr_per_b);
        for (int c = 0; c < nch[d]; c++) nl[c] = model_out(d, c, pwm);
        for (int c = 0; c < nch[d]; c++) begin
          if (we && wc == c) begin
            m_mode[d][c] = wm;
            m_per[d][c]  = wp;
            m_n[d][c]    = 0;
          end else if (tk) begin
            m_n[d][c]++;
          end
        end
        k_m[d] = k;
        exp_led[d] = nl;
        exp_tick[d] = tk;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (o_led_a !== 4'b0000 || o_tick_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: led=%b tick=%b expected led=0000 tick=0", o_led_a, o_tick_a);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if (o_led_a !== exp_led[0][3:0] || o_tick_a !== exp_tick[0]) begin
        failures++;
        $display("FAIL default_blink cyc%0d: led=%b tick=%b expected led=%b tick=%b",
                 i, o_led_a, o_tick_a, exp_led[0][3:0], exp_tick[0]);
      end
      checks++;
      if (o_led_b !== exp_led[1][4:0]) begin
        failures++;
        $display("FAIL default_blink_b cyc%0d: led=%b expected=%b", i, o_led_b, exp_led[1][4:0]);
      end
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_on_off();
    wr_en_a = 1'b1; wr_ch_a = 2'd2; wr_mode_a = 2'd1; wr_per_a = 8'($urandom_range(0, 255));
    cycle();
    wr_en_a = 1'b0;
    for (int i = 1; i < 24; i++) begin
      if (i == 10) begin
        wr_en_a = 1'b1; wr_ch_a = 2'd2; wr_mode_a = 2'd0; wr_per_a = 8'($urandom_range(0, 255));
      end
      cycle();
      wr_en_a = 1'b0;
      checks++;
      if (o_led_a !== exp_led[0][3:0]) begin
        failures++;
        $display("FAIL on_off cyc%0d: led=%b expected=%b", i, o_led_a, exp_led[0][3:0]);
      end
      if (i >= 2 && i <= 10) begin
        checks++;
        if (o_led_a[2] !== 1'b1) begin
          failures++;
          $display("FAIL on_latency cyc%0d: led2=%b expected=1", i, o_led_a[2]);
        end
      end
      if (i >= 12) begin
        checks++;
        if (o_led_a[2] !== 1'b0) begin
          failures++;
          $display("FAIL off_latency cyc%0d: led2=%b expected=0", i, o_led_a[2]);
        end
      end
    end
    $display("test_on_off done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_breathe();
    int hi_cnt = 0;
    wr_en_a = 1'b1; wr_ch_a = 2'd0; wr_mode_a = 2'd3; wr_per_a = 8'd0;
    cycle();
    wr_en_a = 1'b0;
    for (int i = 0; i < 2 * DMAX * D + 48; i++) begin
      cycle();
      hi_cnt += int'(o_led_a[0]);
      checks++;
      if (o_led_a !== exp_led[0][3:0]) begin
        failures++;
        $display("FAIL breathe cyc%0d: led=%b expected=%b", i, o_led_a, exp_led[0][3:0]);
      end
    end
    $display("test_breathe done: ch0 high cycles=%0d checks=%0d failures=%0d", hi_cnt, checks, failures);
  endtask

  task automatic test_collision();
    int guard = 0;
    while ((k_m[0] % D) != D - 1 && guard < 2 * D) begin
      cycle();
      guard++;
    end
    checks++;
    if ((k_m[0] % D) != D - 1) begin
      failures++;
      $display("FAIL collision_align: phase=%0d expected=%0d", k_m[0] % D, D - 1);
    end
    wr_en_a = 1'b1; wr_ch_a = 2'd1; wr_mode_a = 2'd2; wr_per_a = 8'd0;
    cycle();
    wr_en_a = 1'b0;
    checks++;
    if (o_tick_a !== 1'b1) begin
      failures++;
      $display("FAIL collision_tick: tick=%b expected=1", o_tick_a);
    end
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if (o_led_a !== exp_led[0][3:0]) begin
        failures++;
        $display("FAIL collision cyc%0d: led=%b expected=%b", i, o_led_a, exp_led[0][3:0]);
      end
      if (i <= D + 1) begin
        checks++;
        if (o_led_a[1] !== ((i == D + 1) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL collision_first_toggle cyc%0d: led1=%b expected=%b",
                   i, o_led_a[1], (i == D + 1));
        end
      end
    end
    $display("test_collision done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_illegal_channel();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_en_b = 1'b1;
        wr_ch_b = 3'($urandom_range(5, 7));
        wr_mode_b = 2'($urandom_range(0, 3));
        wr_per_b = 8'($urandom_range(0, 255));
      end
      cycle();
      wr_en_b = 1'b0;
      checks++;
      if (o_led_b !== exp_led[1][4:0] || o_tick_b !== exp_tick[1]) begin
        failures++;
        $display("FAIL illegal_ch cyc%0d: led=%b tick=%b expected led=%b tick=%b",
                 i, o_led_b, o_tick_b, exp_led[1][4:0], exp_tick[1]);
      end
    end
    $display("test_illegal_channel done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        wr_en_a = 1'b1; wr_ch_a = 2'($urandom_range(0, 3));
        wr_mode_a = 2'($urandom_range(0, 3)); wr_per_a = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) begin
        wr_en_b = 1'b1; wr_ch_b = 3'($urandom_range(0, 7));
        wr_mode_b = 2'($urandom_range(0, 3)); wr_per_b = 8'($urandom_range(0, 2));
      end
      cycle();
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
      checks++;
      if (o_led_a !== exp_led[0][3:0] || o_led_b !== exp_led[1][4:0]) begin
        failures++;
        $display("FAIL random cyc%0d: led_a=%b led_b=%b expected led_a=%b led_b=%b",
                 i, o_led_a, o_led_b, exp_led[0][3:0], exp_led[1][4:0]);
      end
    end
    $display("test_random done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_async_reset();
    wr_en_a = 1'b1; wr_ch_a = 2'd0; wr_mode_a = 2'd3; wr_per_a = 8'd0;
    wr_en_b = 1'b1; wr_ch_b = 3'd4; wr_mode_b = 2'd1; wr_per_b = 8'd0;
    cycle();
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    for (int i = 0; i < 80; i++) cycle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_led_a !== 4'b0000 || o_led_b !== 5'b00000 || o_tick_a !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: led_a=%b led_b=%b tick=%b expected 0000 00000 0",
               o_led_a, o_led_b, o_tick_a);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if (o_led_a !== exp_led[0][3:0] || o_tick_a !== exp_tick[0] || o_led_b !== exp_led[1][4:0]) begin
        failures++;
        $display("FAIL restart cyc%0d: led_a=%b tick=%b led_b=%b expected led_a=%b tick=%b led_b=%b",
                 i, o_led_a, o_tick_a, o_led_b, exp_led[0][3:0], exp_tick[0], exp_led[1][4:0]);
      end
    end
    $display("test_async_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_on_off();
    test_breathe();
    test_collision();
    test_illegal_channel();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
